// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: phase codes, key codes, FSM states.
package calc_pkg;

    // Calculator phases, Gray coded so each legal step flips one bit.
    localparam logic [1:0] PH_ENTER_A = 2'b00;
    localparam logic [1:0] PH_HAVE_A  = 2'b01;
    localparam logic [1:0] PH_OP_SET  = 2'b11;
    localparam logic [1:0] PH_ENTER_B = 2'b10;

    // Keypad codes above the digits.
    localparam logic [3:0] KEY_CLR  = 4'hA;
    localparam logic [3:0] KEY_SUB  = 4'hB;
    localparam logic [3:0] KEY_ADD  = 4'hC;
    localparam logic [3:0] KEY_EQ   = 4'hD;
    localparam logic [3:0] KEY_GETM = 4'hE;
    localparam logic [3:0] KEY_SETM = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StExec
    } seq_state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Key, decoder and ALU handshake bundle between the sequencer and its neighbours.
interface calc_sequencer_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic [5:0] dec_addr;
    logic [7:0] dec_cont;
    logic [7:0] ctl_word;
    logic       ctl_valid;
    logic       alu_start;
    logic       alu_done;
    logic [1:0] phase;
    logic       busy;
    logic       digit_drop;
    logic       err;

    // Sequencer side.
    modport master (
        input  key_code, key_valid, dec_cont, alu_done,
        output key_ready, dec_addr, ctl_word, ctl_valid, alu_start, phase, busy, digit_drop, err
    );

    // Keypad / decoder / ALU side.
    modport slave (
        output key_code, key_valid, dec_cont, alu_done,
        input  key_ready, dec_addr, ctl_word, ctl_valid, alu_start, phase, busy, digit_drop, err
    );
endinterface

// File: rtl/calc_timeout_cnt.sv
// Loadable down-counter; expired is high while the count sits at zero.
module calc_timeout_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q;

    // Count register: load wins over decrement, decrement stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: accepts keys, tracks the phase, strobes decoded control words and
// runs the ALU start/done handshake on "=".
module calc_sequencer #(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             rst,
    calc_sequencer_if.master bus
);
    import calc_pkg::*;

    localparam int unsigned     CntW    = $clog2(MAX_DIGITS + 1);
    localparam int unsigned     TmrW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_DIGITS);
    // Loaded during DECODE so the start cycle is the first of TIMEOUT waiting cycles.
    localparam logic [TmrW-1:0] TmrLoad = TmrW'(TIMEOUT - 1);

    seq_state_e      state_q, state_d;
    logic [3:0]      key_q;
    logic [1:0]      phase_q, phase_d;
    logic [CntW-1:0] count_q, count_d;
    logic            err_q, err_d;
    logic [7:0]      ctl_word_q;
    logic            ctl_valid_q, alu_start_q, drop_q;

    logic key_ready, key_accept, drop, goto_exec;
    logic tmr_load, tmr_en, tmr_expired, alu_ok, alu_timeout;

    assign key_accept  = bus.key_valid && key_ready;
    assign goto_exec   = (key_q == KEY_EQ) && (phase_q == PH_ENTER_B);
    assign alu_ok      = (state_q == StExec) && bus.alu_done;
    assign alu_timeout = (state_q == StExec) && !bus.alu_done && tmr_expired;

    calc_timeout_cnt #(
        .WIDTH (TmrW)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TmrLoad),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (key_accept) state_d = StDecode;
            StDecode: state_d = goto_exec ? StExec : StIdle;
            StExec:   if (alu_ok || alu_timeout) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs: key handshake and timer control.
    always_comb begin
        key_ready = (state_q == StIdle);
        tmr_load  = (state_q == StDecode) && goto_exec;
        tmr_en    = (state_q == StExec);
    end

    // Phase, digit count and error updates for the decoded key or ALU outcome.
    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        err_d   = err_q;
        drop    = 1'b0;
        if (state_q == StDecode) begin
            if (key_q == KEY_CLR) begin
                phase_d = PH_ENTER_A;
                count_d = '0;
                err_d   = 1'b0;
            end else if (is_digit(key_q)) begin
                if (count_q == CntMax) begin
                    drop = 1'b1;
                end else begin
                    // HAVE_A keeps its count; the operand there is already closed.
                    if (phase_q != PH_HAVE_A) count_d = count_q + CntW'(1);
                    if (phase_q == PH_ENTER_A && count_q == '0) phase_d = PH_HAVE_A;
                    if (phase_q == PH_OP_SET) phase_d = PH_ENTER_B;
                end
            end else if (key_q == KEY_SUB || key_q == KEY_ADD) begin
                if (phase_q == PH_HAVE_A) begin
                    phase_d = PH_OP_SET;
                    count_d = '0;
                end
            end else if (key_q == KEY_GETM) begin
                // A recalled operand is full; further digits are dropped.
                count_d = CntMax;
                if (phase_q == PH_ENTER_A) phase_d = PH_HAVE_A;
                else if (phase_q == PH_OP_SET) phase_d = PH_ENTER_B;
            end
        end else if (alu_ok) begin
            phase_d = PH_HAVE_A;
            count_d = '0;
        end else if (alu_timeout) begin
            err_d   = 1'b1;
            phase_d = PH_ENTER_A;
            count_d = '0;
        end
    end

    // Datapath registers: latched key, phase/count/err and one-cycle strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q       <= '0;
            phase_q     <= PH_ENTER_A;
            count_q     <= '0;
            err_q       <= 1'b0;
            ctl_word_q  <= '0;
            ctl_valid_q <= 1'b0;
            alu_start_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            count_q     <= count_d;
            err_q       <= err_d;
            ctl_valid_q <= (state_q == StDecode) && !drop;
            alu_start_q <= (state_q == StDecode) && goto_exec;
            drop_q      <= drop;
            if (key_accept) key_q <= bus.key_code;
            if (state_q == StDecode) ctl_word_q <= bus.dec_cont;
        end
    end

    assign bus.key_ready  = key_ready;
    assign bus.busy       = !key_ready;
    assign bus.dec_addr   = {phase_q, key_q};
    assign bus.ctl_word   = ctl_word_q;
    assign bus.ctl_valid  = ctl_valid_q;
    assign bus.alu_start  = alu_start_q;
    assign bus.phase      = phase_q;
    assign bus.digit_drop = drop_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a scoreboard of expected control strobes.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_start = 0;
    int   accepts;
    logic [8:0] exp_q[$];   // {drop, ctl_word}

    calc_sequencer_if bus ();

    calc_sequencer #(
        .MAX_DIGITS (4),
        .TIMEOUT    (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference decoder: arbitrary but address-unique control word.
    function automatic logic [7:0] dec_fn(input logic [5:0] a);
        return {a[1:0], a} ^ 8'hA5;
    endfunction

    assign bus.dec_cont = dec_fn(bus.dec_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe or drop must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.alu_start === 1'b1) n_start++;
        if (bus.ctl_valid === 1'b1 || bus.digit_drop === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {bus.digit_drop, bus.ctl_valid}, 2'b00);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("sb_ctl_valid", bus.ctl_valid, !e[8]);
                check("sb_digit_drop", bus.digit_drop, e[8]);
                if (!e[8]) check("sb_ctl_word", bus.ctl_word, e[7:0]);
            end
        end
    end

    task automatic press(input logic [3:0] k, input logic [1:0] ph_before, input logic drop,
                         input logic [1:0] ph_after);
        bit ok = 1'b0;
        exp_q.push_back({drop, dec_fn({ph_before, k})});
        @(negedge clk);
        bus.key_code  = k;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.key_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("key_accept", ok, 1);
        @(posedge clk);
        #1 bus.key_valid = 1'b0;
        @(negedge clk);
        check("dec_addr", bus.dec_addr, {ph_before, k});
        check("busy_decode", bus.busy, 1);
        @(negedge clk);
        check("phase_after", bus.phase, ph_after);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.key_code  = '0;
        bus.key_valid = 1'b0;
        bus.alu_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_phase", bus.phase, PH_ENTER_A);
        check("rst_key_ready", bus.key_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_ctl_word", bus.ctl_word, 0);
        check("rst_ctl_valid", bus.ctl_valid, 0);
        check("rst_alu_start", bus.alu_start, 0);
        check("rst_digit_drop", bus.digit_drop, 0);
        check("rst_err", bus.err, 0);
        check("rst_dec_addr", bus.dec_addr, 0);

        // First digit leaves ENTER_A.
        press(4'd5, PH_ENTER_A, 1'b0, PH_HAVE_A);

        // 3 + 4 = with alu_done three cycles after start.
        press(KEY_CLR, PH_HAVE_A, 1'b0, PH_ENTER_A);
        press(4'd3, PH_ENTER_A, 1'b0, PH_HAVE_A);
        press(KEY_ADD, PH_HAVE_A, 1'b0, PH_OP_SET);
        press(4'd4, PH_OP_SET, 1'b0, PH_ENTER_B);
        press(KEY_EQ, PH_ENTER_B, 1'b0, PH_ENTER_B);
        check("exec_alu_start", bus.alu_start, 1);
        check("exec_ready0", bus.key_ready, 0);
        @(negedge clk);
        check("exec_start_pulse", bus.alu_start, 0);
        check("exec_ready1", bus.key_ready, 0);
        @(negedge clk);
        check("exec_ready2", bus.key_ready, 0);
        @(posedge clk);
        #1 bus.alu_done = 1'b1;
        @(negedge clk);
        check("exec_ready3", bus.key_ready, 0);
        @(posedge clk);
        #1 bus.alu_done = 1'b0;
        @(negedge clk);
        check("done_phase", bus.phase, PH_HAVE_A);
        check("done_ready", bus.key_ready, 1);
        check("start_count1", n_start, 1);

        // Digit limit: fifth digit of operand B is dropped.
        press(KEY_CLR, PH_HAVE_A, 1'b0, PH_ENTER_A);
        press(4'd7, PH_ENTER_A, 1'b0, PH_HAVE_A);
        press(KEY_SUB, PH_HAVE_A, 1'b0, PH_OP_SET);
        press(4'd1, PH_OP_SET, 1'b0, PH_ENTER_B);
        press(4'd2, PH_ENTER_B, 1'b0, PH_ENTER_B);
        press(4'd3, PH_ENTER_B, 1'b0, PH_ENTER_B);
        press(4'd4, PH_ENTER_B, 1'b0, PH_ENTER_B);
        press(4'd5, PH_ENTER_B, 1'b1, PH_ENTER_B);

        // ALU never answers: timeout after 15 cycles.
        press(KEY_EQ, PH_ENTER_B, 1'b0, PH_ENTER_B);
        check("to_alu_start", bus.alu_start, 1);
        repeat (14) @(negedge clk);
        check("to_err_early", bus.err, 0);
        check("to_ready_early", bus.key_ready, 0);
        @(negedge clk);
        check("to_err", bus.err, 1);
        check("to_phase", bus.phase, PH_ENTER_A);
        check("to_ready", bus.key_ready, 1);
        press(KEY_CLR, PH_ENTER_A, 1'b0, PH_ENTER_A);
        check("clr_err", bus.err, 0);

        // Reset during DECODE suppresses the strobe.
        bus.key_code  = 4'd5;
        bus.key_valid = 1'b1;
        @(posedge clk);
        #1 bus.key_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstdec_ctl_valid", bus.ctl_valid, 0);
        check("rstdec_phase", bus.phase, PH_ENTER_A);
        check("rstdec_ready", bus.key_ready, 1);
        check("rstdec_ctl_word", bus.ctl_word, 0);

        // key_valid held: one acceptance per ready window; plus in ENTER_A holds phase.
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, dec_fn({PH_ENTER_A, KEY_ADD})});
        accepts = 0;
        bus.key_code  = KEY_ADD;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.key_ready === 1'b1) accepts++;
            if (i < 5) @(negedge clk);
        end
        bus.key_valid = 1'b0;
        @(negedge clk);
        check("held_accepts", accepts, 3);
        check("held_phase", bus.phase, PH_ENTER_A);

        // getM fills the operand; next digit is dropped.
        press(KEY_GETM, PH_ENTER_A, 1'b0, PH_HAVE_A);
        press(4'd4, PH_HAVE_A, 1'b1, PH_HAVE_A);

        // alu_done outside EXEC is ignored.
        @(posedge clk);
        #1 bus.alu_done = 1'b1;
        @(posedge clk);
        #1 bus.alu_done = 1'b0;
        @(negedge clk);
        check("stray_done_phase", bus.phase, PH_HAVE_A);
        check("stray_done_ready", bus.key_ready, 1);

        repeat (2) @(negedge clk);
        check("start_count_total", n_start, 2);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Main calculator sequencer. Accepts debounced key events from the keypad scanner, keeps the 2-bit calculator phase, and drives the phase/key control decoder with the 6-bit {phase,key} address. Issues the decoded 8-bit control word to the datapath as a one-cycle strobe. Runs the ALU start/done handshake on "=" and enforces a digit-count limit per operand.

Parameters:
MAX_DIGITS, 4, max digits accepted per operand; further digits are dropped.
TIMEOUT, 15, cycles to wait for alu_done before aborting to phase 00.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
key_code  in  4  key: 0-9 digits, A=10 clear, B=11 minus, C=12 plus, D=13 equals, E=14 getM, F=15 setM
key_valid  in  1  key event present; held until accepted
key_ready  out  1  sequencer can accept a key
dec_addr  out  6  {phase[1:0], key[3:0]} to control decoder
dec_cont  in  8  control word returned by decoder (combinational)
ctl_word  out  8  registered copy of dec_cont
ctl_valid  out  1  one-cycle strobe qualifying ctl_word
alu_start  out  1  one-cycle ALU start pulse
alu_done  in  1  ALU result ready (one-cycle pulse)
phase  out  2  current calculator phase
busy  out  1  high whenever key_ready is low
digit_drop  out  1  one-cycle pulse when a digit is discarded by the limit
err  out  1  sticky ALU-timeout flag; cleared by key A or rst

Behaviour:
- Reset values: phase=00, key_ready=1, busy=0, ctl_word=0, ctl_valid=0, alu_start=0, digit_drop=0, err=0, digit count=0, dec_addr=0.
- Phase encoding (Gray): 00 ENTER_A, 01 HAVE_A, 11 OP_SET, 10 ENTER_B. Shared package constants.
- Internal FSM: IDLE, DECODE, EXEC.
- IDLE: key_ready=1. On key_valid&key_ready, latch key_code into key_q and go to DECODE. key_ready drops the following cycle.
- DECODE (1 cycle): dec_addr={phase,key_q}. Register ctl_word<=dec_cont. In the same cycle, update phase and counters per the rules below. ctl_valid is high in the next cycle, aligned with ctl_word. Next state is IDLE, or EXEC for "=" in ENTER_B.
- Key-to-latch latency: 2 cycles. Minimum spacing between accepted keys: 2 cycles.
- Phase transitions:
  - Key A, any phase: go to 00, count=0, err=0.
  - 00: digit goes to 01 only when count reaches 1, else stays 00. E goes to 01.
  - 01: B or C goes to 11, count=0.
  - 11: B/C stay in 11 (operator replaced). Digit or E goes to 10.
  - 10: digit stays 10. D goes to EXEC.
  - All other keys leave phase unchanged.
- Digits increment count in phases 00 and 11/10, saturating at MAX_DIGITS.
- Digit limit: a digit arriving with count==MAX_DIGITS gets no ctl_valid and raises digit_drop for 1 cycle. The key is still consumed.
- E (getM) sets count=MAX_DIGITS, so subsequent digits are dropped.
- EXEC:
  - alu_start pulses in the first EXEC cycle (same cycle ctl_valid strobes the D word).
  - key_ready stays 0.
  - On alu_done: phase=01, count=0, return to IDLE.
  - alu_done in the same cycle as alu_start counts as done.
  - No alu_done within TIMEOUT cycles after alu_start: err=1, phase=00, return to IDLE.
  - alu_done outside EXEC is ignored.
- ctl_word passes decoder don't-care bits through unchanged. Consumers must honour only bits the decoder defines for that address.
- rst mid-EXEC or mid-DECODE: all state returns to reset values next cycle. No ctl_valid or alu_start is emitted.
- key_valid while busy: not accepted, no side effects.

Decomposition:
- Package calc_pkg: phase constants (PH_ENTER_A, PH_HAVE_A, PH_OP_SET, PH_ENTER_B), key constants (KEY_CLR, KEY_SUB, KEY_ADD, KEY_EQ, KEY_GETM, KEY_SETM), FSM state encoding.
- One sub-module, calc_timeout_cnt: loadable down-counter with expiry flag, used in EXEC.
- The control decoder stays external and is wired through dec_addr/dec_cont.

Test Plan:
- Reset, then key 5 -> dec_addr=6'b000101 in DECODE; ctl_valid 2 cycles after accept with ctl_word=dec_cont; phase=01.
- Keys 3, C, 4, D with alu_done 3 cycles after alu_start -> phase sequence 00,01,11,10; alu_start one pulse; phase=01 after done; key_ready low throughout EXEC.
- MAX_DIGITS=4, five digits in phase 11/10 -> 4 ctl_valid strobes; fifth gives digit_drop=1, no ctl_valid.
- Key D in phase 10 with alu_done never asserted -> err=1 after 15 cycles, phase=00; then key A -> err=0.
- rst asserted in the cycle after key accept -> no ctl_valid, phase=00, key_ready=1 next cycle.
- key_valid held high across busy cycles -> exactly one acceptance per key_ready window; key C in phase 00 -> ctl_valid strobed, phase stays 00.
